// File: rtl/comparador_serial_der_izq_pkg.sv
// Shared encodings for the LSB-first serial magnitude comparator.
package comparador_serial_der_izq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [1:0] EQ = 2'b00;
  localparam logic [1:0] GT = 2'b01;
  localparam logic [1:0] LT = 2'b10;

endpackage

// File: rtl/comparador_serial_der_izq_celda.sv
// Per-bit update cell: a differing bit pair overrides whatever lower bits decided.
module celda_der_izq
  import comparador_serial_der_izq_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic [1:0] rel_in,
  output logic [1:0] rel_out
);

  always_comb begin
    rel_out = rel_in;
    if (a != b) rel_out = a ? GT : LT;
  end

endmodule

// File: rtl/comparador_serial_der_izq.sv
// Bit-serial unsigned comparator, LSB first, with start/busy/done handshake.
module comparador_serial_der_izq
  import comparador_serial_der_izq_pkg::*;
#(
  parameter int N  = 4,
  parameter int CW = $clog2(N+1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         busy,
  output logic         done,
  output logic         mayor,
  output logic         igual,
  output logic         menor
);

  state_e        state_q, state_d;
  logic [N-1:0]  sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    rel_q, rel_d, rel_cell;
  logic          busy_q, busy_d, done_q, done_d;
  logic          mayor_q, mayor_d, igual_q, igual_d, menor_q, menor_d;

  celda_der_izq u_celda (
    .a       (sa_q[0]),
    .b       (sb_q[0]),
    .rel_in  (rel_q),
    .rel_out (rel_cell)
  );

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    rel_d   = rel_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mayor_d = mayor_q;
    igual_d = igual_q;
    menor_d = menor_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = A;
          sb_d    = B;
          cnt_d   = '0;
          rel_d   = EQ;
          mayor_d = 1'b0;
          igual_d = 1'b0;
          menor_d = 1'b0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        rel_d = rel_cell;
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N-1)) state_d = DONE;
      end
      DONE: begin
        mayor_d = (rel_q == GT);
        igual_d = (rel_q == EQ);
        menor_d = (rel_q == LT);
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      rel_q   <= EQ;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mayor_q <= 1'b0;
      igual_q <= 1'b0;
      menor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      rel_q   <= rel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      mayor_q <= mayor_d;
      igual_q <= igual_d;
      menor_q <= menor_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign mayor = mayor_q;
  assign igual = igual_q;
  assign menor = menor_q;

endmodule

// File: tb/tb_comparador_serial_der_izq.sv
// Directed bench for the serial comparator: latency, hold, ignored start, reset, full sweep.
module tb_comparador_serial_der_izq;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [N-1:0] A = '0, B = '0;
  logic         busy, done, mayor, igual, menor;

  int checks = 0;
  int errors = 0;

  comparador_serial_der_izq #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .mayor(mayor), .igual(igual), .menor(menor)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  // MSB-first parallel chain: first differing bit from the top decides.
  function automatic logic [2:0] chain_ref(input logic [N-1:0] a, input logic [N-1:0] b);
    for (int i = N-1; i >= 0; i--)
      if (a[i] != b[i]) return a[i] ? 3'b100 : 3'b001;
    return 3'b010;
  endfunction

  function automatic logic [2:0] cmp_ref(input logic [N-1:0] a, input logic [N-1:0] b);
    return {a > b, a == b, a < b};
  endfunction

  // Inputs change on negedges; outputs are sampled on negedges.
  // inj >= 0 pulses a stray start (with junk operands) at that sample point.
  task automatic run(input logic [N-1:0] a, input logic [N-1:0] b, input logic [2:0] exp,
                     input int inj, input bit full, input string tag);
    A = a; B = b; start = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= N+1; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == inj) begin start = 1'b1; A = 4'b1111; B = 4'b0000; end
      if (k <= N) begin
        if (full) begin
          chk({tag, "_busy"}, busy, 1'b1);
          chk({tag, "_done_early"}, done, 1'b0);
        end
        if (k == 0) chk({tag, "_flags_clr"}, {mayor, igual, menor}, 3'b000);
      end else begin
        chk({tag, "_done"}, {done, busy}, 2'b10);
        chk({tag, "_flags"}, {mayor, igual, menor}, exp);
      end
      if (k <= N) @(posedge clk);
    end
  endtask

  initial begin
    #12;
    chk("rst_outs", {busy, done, mayor, igual, menor}, 5'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("idle_outs", {busy, done, mayor, igual, menor}, 5'b0);

    run(4'b0000, 4'b0000, 3'b010, -1, 1'b1, "zeros");
    @(negedge clk);
    run(4'b1000, 4'b0111, 3'b100, -1, 1'b1, "msb_ovr");
    @(negedge clk);
    run(4'b0101, 4'b0110, 3'b001, -1, 1'b1, "lt");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_flags", {mayor, igual, menor}, 3'b001);
      chk("hold_done", {done, busy}, 2'b00);
    end

    // Stray start at SHIFT cycle 2 must not disturb the 0101 vs 0110 result.
    run(4'b0101, 4'b0110, 3'b001, 1, 1'b1, "ign_start");
    start = 1'b0;
    @(negedge clk);
    chk("ign_no_restart", busy, 1'b0);

    // Reset during SHIFT cycle 2.
    A = 4'b1010; B = 4'b0101; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {busy, done, mayor, igual, menor}, 5'b0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_idle", {busy, done, mayor, igual, menor}, 5'b0);
    run(4'b1111, 4'b1111, 3'b010, -1, 1'b1, "ones");

    // Exhaustive sweep, each start issued right after the previous done.
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++) begin
        @(negedge clk);
        run(N'(a), N'(b), cmp_ref(N'(a), N'(b)), -1, 1'b0, "sweep");
        chk("sweep_chain", {mayor, igual, menor}, chain_ref(N'(a), N'(b)));
      end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1);
  end

endmodule
